// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor built around one full-adder
// slice and one carry flop, processing one operand bit per clock, LSB first.
// Subtraction is a + ~b + 1, so in subtract mode cout = 1 means "no borrow".
// The sum, cout and overflow outputs only change when an operation completes.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [CW-1:0]    count;

   logic             bit_sum;
   logic             carry_next;
   logic             last_bit;

   // Single full-adder slice working on the current LSBs of the shift registers
   always_comb begin
      bit_sum    = op_a[0] ^ op_b[0] ^ carry;
      carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
   end

   assign last_bit = (count == CW'(WIDTH - 1));

   // Control FSM and serial datapath; the DONE cycle accepts a new start like IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         res      <= '0;
         carry    <= 1'b0;
         count    <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (start) begin
                  op_a  <= a;
                  op_b  <= mode ? ~b : b;
                  carry <= mode ? 1'b1 : cin;
                  count <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            RUN: begin
               res   <= {bit_sum, res[WIDTH-1:1]};
               op_a  <= op_a >> 1;
               op_b  <= op_b >> 1;
               carry <= carry_next;
               count <= count + 1'b1;
               if (last_bit) begin
                  sum      <= {bit_sum, res[WIDTH-1:1]};
                  cout     <= carry_next;
                  overflow <= carry ^ carry_next;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  state    <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: exercises serial_add_sub (WIDTH=8) with directed cases
// and randomized operations, comparing against an arithmetic reference model.
module tb_serial_add_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         mode;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;

   int compared;
   int mismatched;
   logic [W-1:0] heldSum;

   serial_add_sub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .mode     (mode),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Reference result {overflow, cout, sum} from plain integer arithmetic
   function automatic logic [W+1:0] refModel(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rm, input logic rc);
      int unsigned ua;
      int unsigned ub;
      int          sa;
      int          sb;
      int unsigned full;
      int          sres;
      logic        ovf;
      ua = ra;
      ub = rb;
      sa = $signed(ra);
      sb = $signed(rb);
      if (!rm) begin
         full = ua + ub + rc;
         sres = sa + sb + int'(rc);
      end else begin
         full = ua + (1 << W) - ub;
         sres = sa - sb;
      end
      ovf = (sres > (1 << (W - 1)) - 1) || (sres < -(1 << (W - 1)));
      return {ovf, full[W], full[W-1:0]};
   endfunction

   // Drive a start with operands at the current negedge, release it after the accepting edge
   task automatic startOp(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tm, input logic tc);
      a     = ta;
      b     = tb_;
      mode  = tm;
      cin   = tc;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
      mode  = 1'($urandom);
      cin   = 1'($urandom);
   endtask

   // Follow an operation from the negedge after acceptance until done, checking timing and result
   task automatic waitResult(input string tag, input logic [W+1:0] expected, input bit pulseMid);
      int k;
      int busyCnt;
      k       = 0;
      busyCnt = 0;
      while (done !== 1'b1 && k < 40) begin
         if (busy === 1'b1) busyCnt++;
         if (k == 4) checkOutput({tag, "_sum_held"}, 32'(sum), 32'(heldSum));
         if (pulseMid && k == 3) begin
            start = 1'b1;
            a     = W'($urandom);
            b     = W'($urandom);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      checkOutput({tag, "_latency"}, 32'(k), 32'(W));
      checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(W));
      checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      checkOutput({tag, "_result"}, 32'({overflow, cout, sum}), 32'(expected));
      heldSum = expected[W-1:0];
   endtask

   task automatic applyStimulus(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                input logic tm, input logic tc, input bit pulseMid);
      logic [W+1:0] expected;
      expected = refModel(ta, tb_, tm, tc);
      @(negedge clk);
      startOp(ta, tb_, tm, tc);
      waitResult(tag, expected, pulseMid);
   endtask

   // Main stimulus sequence
   initial begin
      logic         lowCout;
      logic [W-1:0] lowSum;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rm;
      logic         rc;
      bit           sawDone;

      compared   = 0;
      mismatched = 0;
      heldSum    = '0;
      rst_n      = 1'b0;
      start      = 1'b0;
      mode       = 1'b0;
      a          = '0;
      b          = '0;
      cin        = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs", 32'({busy, done, overflow, cout, sum}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("idle_outputs", 32'({busy, done, overflow, cout, sum}), 32'd0);

      applyStimulus("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b0);
      checkOutput("add_3c_0f_const", 32'({overflow, cout, sum}), 32'h04B);
      @(negedge clk);
      checkOutput("done_one_cycle", 32'(done), 32'd0);

      applyStimulus("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      checkOutput("add_ff_01_const", 32'({overflow, cout, sum}), 32'h100);
      applyStimulus("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
      checkOutput("add_7f_01_const", 32'({overflow, cout, sum}), 32'h280);
      applyStimulus("sub_05_07", 8'h05, 8'h07, 1'b1, 1'b1, 1'b0);
      checkOutput("sub_05_07_const", 32'({overflow, cout, sum}), 32'h0FE);
      applyStimulus("sub_80_01", 8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
      checkOutput("sub_80_01_const", 32'({overflow, cout, sum}), 32'h37F);

      // 16-bit chain 0x01FF + 0x0001 as two words, carry fed back from the DUT
      applyStimulus("chain_low", 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      lowCout = cout;
      lowSum  = sum;
      applyStimulus("chain_high", 8'h01, 8'h00, 1'b0, lowCout, 1'b0);
      checkOutput("chain_16bit", 32'({cout, sum, lowSum}), 32'h00200);

      // Start pulsed mid-run must be ignored
      applyStimulus("mid_start", 8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
      checkOutput("mid_start_const", 32'({overflow, cout, sum}), 32'h047);

      // Start held in the DONE cycle: next operation follows with no idle cycle
      startOp(8'h5A, 8'h21, 1'b1, 1'b0);
      waitResult("b2b_first", refModel(8'h5A, 8'h21, 1'b1, 1'b0), 1'b0);
      startOp(8'h40, 8'h40, 1'b0, 1'b0);
      waitResult("b2b_second", refModel(8'h40, 8'h40, 1'b0, 1'b0), 1'b0);

      // Reset asserted for one cycle while bit 4 is being processed
      @(negedge clk);
      startOp(8'hAA, 8'h33, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_outputs", 32'({busy, done, overflow, cout, sum}), 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      heldSum = '0;
      sawDone = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done === 1'b1 || busy === 1'b1) sawDone = 1'b1;
         @(negedge clk);
      end
      checkOutput("abort_no_done", 32'(sawDone), 32'd0);
      applyStimulus("after_abort", 8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
      checkOutput("after_abort_const", 32'({overflow, cout, sum}), 32'h030);

      // Randomized operations, some issued back-to-back from the DONE cycle
      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rm = 1'($urandom);
         rc = 1'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            startOp(ra, rb, rm, rc);
            waitResult("rand_b2b", refModel(ra, rb, rm, rc), 1'b0);
         end else begin
            applyStimulus("rand", ra, rb, rm, rc, ($urandom_range(0, 3) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised bit-serial adder/subtractor for the COA lab datapath. It generalises the combinational 1-bit full adder into a WIDTH-bit sequential unit. The unit reuses one full-adder slice and one carry flip-flop, processing one bit per clock, LSB first. It is started by a start/done handshake and sits beside the ALU as the low-area arithmetic option for multi-word add/subtract chains.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only when unit is not busy.
- mode  in  1  0 = add (a + b + cin), 1 = subtract (a - b, cin ignored).
- a  in  WIDTH  operand A, captured on accepted start.
- b  in  WIDTH  operand B, captured on accepted start.
- cin  in  1  carry-in for add, captured on accepted start; enables word chaining.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse: result outputs have just updated.
- sum  out  WIDTH  result; holds the last completed value.
- cout  out  1  final carry; in subtract mode 1 = no borrow (a >= b unsigned).
- overflow  out  1  signed overflow of the last result.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE and clears busy, done, sum, cout, overflow, the internal shift registers, the bit counter and the carry flop, all to 0.
- IDLE, start=1 at an edge:
  - capture a into opA_sr;
  - capture b into opB_sr, or ~b when mode=1;
  - carry flop <= (mode ? 1 : cin);
  - counter <= 0; go to RUN.
- IDLE, start=0: remain in IDLE.
- RUN, each edge:
  - s = opA_sr[0] ^ opB_sr[0] ^ carry;
  - carry <= majority(opA_sr[0], opB_sr[0], carry);
  - res_sr shifts right with s entering at bit WIDTH-1; opA_sr and opB_sr shift right;
  - counter increments.
- On the edge processing bit WIDTH-1 (counter == WIDTH-1):
  - sum <= final res_sr contents, including that bit;
  - cout <= carry out of bit WIDTH-1;
  - overflow <= carry into bit WIDTH-1 XOR carry out of bit WIDTH-1;
  - go to DONE.
- DONE: lasts one cycle, then IDLE. A start seen during the DONE cycle is accepted exactly as in IDLE (back-to-back operation) and moves straight to RUN.
- start during RUN is ignored; a, b, mode and cin may change freely after capture without effect.
- sum, cout and overflow change only on completion. Intermediate shift contents are never visible on the outputs.
- Arithmetic is modulo 2^WIDTH; no saturation.

## Timing
- busy = (state == RUN); done = (state == DONE); both are registered outputs.
- Start accepted at edge E0. Bits are processed at edges E1..E_WIDTH. Results and done become visible after edge E_WIDTH.
- Latency is WIDTH cycles from the accepting edge to done. busy is high for exactly WIDTH cycles.
- Throughput is one operation per WIDTH+1 cycles, start in the DONE cycle included.
- Asserting rst_n=0 mid-RUN aborts immediately: outputs clear to 0 and no done pulse follows. After rst_n deasserts, the first start is accepted normally.

## Test plan
- Reset, then add with WIDTH=8: a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0, overflow=0; done exactly 8 cycles after the accepting edge; busy high for 8 cycles.
- Add wrap/overflow: 0xFF+0x01, cin=0 -> sum=0x00, cout=1, overflow=0. 0x7F+0x01 -> sum=0x80, cout=0, overflow=1.
- Subtract: 0x05-0x07 -> sum=0xFE, cout=0, overflow=0. 0x80-0x01 -> sum=0x7F, cout=1, overflow=1. cin=1 driven during both; result unaffected.
- Chaining, 16-bit add of 0x01FF+0x0001 as two 8-bit words:
  - low word 0xFF+0x01, cin=0 -> sum=0x00, cout=1;
  - feed cout back as cin, high word 0x01+0x00 -> sum=0x02, cout=0.
- Handshake robustness:
  - start pulsed mid-RUN with different operands -> ignored; the original result is produced;
  - start held high in the DONE cycle -> new operation begins with no IDLE cycle between.
- rst_n low for 1 cycle at bit 4 of an operation -> all outputs 0, no done pulse. A following operation 0x10+0x20 -> sum=0x30 after 8 cycles.
